// File: rtl/my_riscv_core_ahb_pkg.sv
// Shared AHB encodings and field widths for the L1 bus matrix.
// Also defines the input-stage state encoding {pend_tran, data_phase}.
package my_riscv_core_ahb_pkg;

    localparam int SIZE_W   = 3;
    localparam int BURST_W  = 3;
    localparam int PROT_W   = 4;
    localparam int MASTER_W = 4;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01
    } hresp_t;

    // Bit 1 is pend_tran, bit 0 is data_phase.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DATA   = 2'b01,
        ST_ADDR_P = 2'b10,
        ST_DATA_N = 2'b11
    } stage_state_t;

    typedef struct packed {
        logic                sel;
        logic [1:0]          trans;
        logic                write;
        logic [SIZE_W-1:0]   size;
        logic [BURST_W-1:0]  burst;
        logic [PROT_W-1:0]   prot;
        logic [MASTER_W-1:0] master;
        logic                mastlock;
    } ctrl_t;

endpackage

// File: rtl/my_riscv_core_input_stage.sv
// Per-master AHB input stage: holds an address phase the output stage has not
// yet taken, and returns the owning output stage's data-phase response.
module my_riscv_core_input_stage
    import my_riscv_core_ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int USER_W = 32
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                HSELS,
    input  logic [ADDR_W-1:0]   HADDRS,
    input  logic [USER_W-1:0]   HAUSERS,
    input  logic [1:0]          HTRANSS,
    input  logic                HWRITES,
    input  logic [SIZE_W-1:0]   HSIZES,
    input  logic [BURST_W-1:0]  HBURSTS,
    input  logic [PROT_W-1:0]   HPROTS,
    input  logic [MASTER_W-1:0] HMASTERS,
    input  logic                HMASTLOCKS,
    input  logic [31:0]         HWDATAS,
    input  logic [31:0]         HWUSERS,
    input  logic                HREADYS,
    output logic                HREADYOUTS,
    output logic [1:0]          HRESPS,
    output logic                sel_ip,
    output logic [ADDR_W-1:0]   addr_ip,
    output logic [USER_W-1:0]   auser_ip,
    output logic [1:0]          trans_ip,
    output logic                write_ip,
    output logic [SIZE_W-1:0]   size_ip,
    output logic [BURST_W-1:0]  burst_ip,
    output logic [PROT_W-1:0]   prot_ip,
    output logic [MASTER_W-1:0] master_ip,
    output logic                mastlock_ip,
    output logic [31:0]         wdata_ip,
    output logic [31:0]         wuser_ip,
    output logic                held_tran_ip,
    input  logic                active_ip,
    input  logic                readyout_ip,
    input  logic [1:0]          resp_ip
);

    stage_state_t state, state_next;
    logic         pend_tran, data_phase;
    logic         pend_next, data_next;
    logic         live_req, accept;

    ctrl_t             live_ctrl, hold_ctrl, mux_ctrl;
    logic [ADDR_W-1:0] hold_addr;
    logic [USER_W-1:0] hold_auser;

    assign {pend_tran, data_phase} = state;

    assign live_req     = HSELS & HTRANSS[1] & HREADYS;
    assign held_tran_ip = pend_tran | live_req;
    assign accept       = held_tran_ip & active_ip & readyout_ip;

    assign live_ctrl = '{sel: HSELS, trans: HTRANSS, write: HWRITES, size: HSIZES,
                         burst: HBURSTS, prot: HPROTS, master: HMASTERS,
                         mastlock: HMASTLOCKS};

    // Capture every sampled address phase until one is left pending, so the
    // held copy is always the transfer the master believes was issued.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hold_ctrl  <= '0;
            hold_addr  <= '0;
            hold_auser <= '0;
        end else if (HREADYS && !pend_tran) begin
            hold_ctrl  <= live_ctrl;
            hold_addr  <= HADDRS;
            hold_auser <= HAUSERS;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= ST_IDLE;
        else          state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        pend_next  = pend_tran;
        data_next  = data_phase;
        HREADYOUTS = 1'b1;
        HRESPS     = RESP_OKAY;

        if (accept)                       pend_next = 1'b0;
        else if (live_req && !pend_tran)  pend_next = 1'b1;

        if (accept)                        data_next = 1'b1;
        else if (data_phase && readyout_ip) data_next = 1'b0;

        state_next = stage_state_t'({pend_next, data_next});

        unique case (state)
            ST_IDLE:            HREADYOUTS = 1'b1;
            ST_ADDR_P:          HREADYOUTS = 1'b0;
            ST_DATA, ST_DATA_N: begin
                HREADYOUTS = readyout_ip;
                HRESPS     = resp_ip;
            end
            default:            HREADYOUTS = 1'b1;
        endcase
    end

    assign mux_ctrl    = pend_tran ? hold_ctrl : live_ctrl;
    assign addr_ip     = pend_tran ? hold_addr : HADDRS;
    assign auser_ip    = pend_tran ? hold_auser : HAUSERS;
    assign sel_ip      = mux_ctrl.sel;
    assign trans_ip    = mux_ctrl.trans;
    assign write_ip    = mux_ctrl.write;
    assign size_ip     = mux_ctrl.size;
    assign burst_ip    = mux_ctrl.burst;
    assign prot_ip     = mux_ctrl.prot;
    assign master_ip   = mux_ctrl.master;
    assign mastlock_ip = mux_ctrl.mastlock;

    assign wdata_ip = HWDATAS;
    assign wuser_ip = HWUSERS;

endmodule
